// File: rtl/sixty_four_bit_multicycle_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock with a start/busy/done handshake
// and produces the sum plus C, V, Z, N condition flags.
module sixty_four_bit_multicycle_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = CHUNK + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, psum_q, sum_q;
   logic               carry_q, busy_q, done_q, cout_q, ovf_q, zero_q, neg_q;
   logic [IW-1:0]      idx_q;

   logic [CW-1:0]      chunk_res;
   logic [WIDTH-1:0]   psum_d;
   logic               cmsb;
   logic               last;

   // Operands shift right one chunk per cycle so the active chunk is always at
   // the bottom; each chunk result enters the partial sum from the top.
   always_comb begin
      chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + CW'(carry_q);
      psum_d    = {chunk_res[CHUNK-1:0], psum_q[WIDTH-1:CHUNK]};
      cmsb      = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];
      last      = (idx_q == IW'(NCHUNK - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  carry_q <= carry_in;
                  psum_q  <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               carry_q <= chunk_res[CHUNK];
               psum_q  <= psum_d;
               idx_q   <= idx_q + IW'(1);
               if (last) begin
                  // Outputs update only here, so partial sums never leak out.
                  sum_q   <= psum_d;
                  cout_q  <= chunk_res[CHUNK];
                  ovf_q   <= chunk_res[CHUNK] ^ cmsb;
                  zero_q  <= (psum_d == '0);
                  neg_q   <= psum_d[WIDTH-1];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_sixty_four_bit_multicycle_adder.sv
// Bench for sixty_four_bit_multicycle_adder: directed vector table, multi-cycle
// handshake sequences and random operands against an a+b+cin reference model.
module tb_sixty_four_bit_multicycle_adder;

   logic        clk = 1'b0;
   logic        reset, start, carry_in;
   logic [63:0] a_in, b_in, sum;
   logic        busy, done, carry_out, overflow, zero, negative;

   int checks = 0;
   int failures = 0;

   sixty_four_bit_multicycle_adder #(.WIDTH(64), .CHUNK(8)) dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
      .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [63:0] exp_sum;
      logic [3:0]  exp_cvzn;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: 65-bit integer sum; V from operand and result signs.
   task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        output logic [63:0] s, output logic [3:0] cvzn);
      logic [64:0] t;
      logic        v;
      t = {1'b0, a} + {1'b0, b} + 65'(cin);
      v = (a[63] == b[63]) && (t[63] != a[63]);
      s = t[63:0];
      cvzn = {t[64], v, t[63:0] == 64'd0, t[63]};
   endtask

   // Issue one op from idle; returns done cycle index relative to start cycle.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         output int lat, output logic busy_ok);
      a_in = a; b_in = b; carry_in = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!done && lat < 20) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t        vecs[7];
   int          lat, cnt, ndone;
   logic        bok;
   logic [63:0] es, first_sum, ra, rb;
   logic [3:0]  ef;
   logic        rc;

   initial begin
      vecs[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 4'b0000};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b1010};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101};
      vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b1110};
      vecs[4] = '{64'd0, 64'd0, 1'b1, 64'd1, 4'b0000};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001};
      vecs[6] = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 64'h0100_0100_0100_0100, 4'b0000};

      reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      chk("reset_outputs", {busy, done, carry_out, overflow, zero, negative}, 6'd0);
      chk("reset_sum", sum, 64'd0);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bok);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
         chk($sformatf("vec%0d_busy_run", i), 64'(bok), 64'd1);
         chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
         chk($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
         chk($sformatf("vec%0d_cvzn", i), 64'({carry_out, overflow, zero, negative}), 64'(vecs[i].exp_cvzn));
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      end

      // start during RUN with new operands must be ignored
      a_in = 64'd5; b_in = 64'd6; carry_in = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a_in = 64'd100; b_in = 64'd100; start = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0; first_sum = '0;
      for (int c = 4; c < 20; c++) begin
         if (done) begin
            if (ndone == 0) first_sum = sum;
            ndone++;
         end
         @(negedge clk);
      end
      chk("ignored_start_done_count", 64'(ndone), 64'd1);
      chk("ignored_start_sum", first_sum, 64'd11);

      // start held high: back-to-back ops, done every 9 cycles
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'b1;
      a_in = ra; b_in = rb; carry_in = rc; start = 1'b1;
      for (int op = 0; op < 4; op++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!done && cnt < 20);
         model(ra, rb, rc, es, ef);
         chk($sformatf("b2b%0d_interval", op), 64'(cnt), 64'd9);
         chk($sformatf("b2b%0d_sum", op), sum, es);
         chk($sformatf("b2b%0d_cvzn", op), 64'({carry_out, overflow, zero, negative}), 64'(ef));
         ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
         a_in = ra; b_in = rb; carry_in = rc;
         if (op == 3) start = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle_after", 64'({busy, done}), 64'd0);

      // reset in cycle 4 of an op aborts it without a done pulse
      a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'hFFFF_FFFF_FFFF_FFFF; carry_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_outputs", {busy, done, carry_out, overflow, zero, negative}, 6'd0);
      chk("midreset_sum", sum, 64'd0);
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("midreset_no_done", 64'(ndone), 64'd0);
      run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat, bok);
      chk("post_reset_latency", 64'(lat), 64'd9);
      chk("post_reset_sum", sum, 64'h2222_2222_2222_2211);
      @(negedge clk);

      // random operands, with some carry-chain-heavy patterns mixed in
      for (int n = 0; n < 3000; n++) begin
         ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: rb = (~ra) ^ (64'd1 << $urandom_range(0, 63));
            default: ;
         endcase
         run_op(ra, rb, rc, lat, bok);
         model(ra, rb, rc, es, ef);
         chk("rand_latency", 64'(lat), 64'd9);
         chk("rand_sum", sum, es);
         chk("rand_cvzn", 64'({carry_out, overflow, zero, negative}), 64'(ef));
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
